dcache_mem_responder: RTL

- Memory-side responder for the data-cache refill/write-back interface.
- Services one line transaction at a time, each raised as `mem_r` (line fetch) or `mem_w` (line write-back) and held until completion.
- Models backing memory as a word-wide synchronous RAM, accessed one beat per word after a programmable access latency.
- Completion is signalled with a single-cycle `mem_ready` pulse. Sits between the D-cache controller and main memory, replacing the ideal memory model in simulation and FPGA builds.

---
 rtl/dcache_mem_pkg.sv | 25 ++
 rtl/dcache_mem_word_ram.sv | 25 ++
 rtl/dcache_mem_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_mem_pkg.sv
// rtl/dcache_mem_pkg.sv - shared types and width helpers for the D-cache memory responder
package dcache_mem_pkg;

  localparam int WORD_W             = 32;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int LINE_W             = WORD_W * WORDS_PER_LINE_DEF;
  localparam int OFFS_W             = $clog2(WORDS_PER_LINE_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int line_width(input int words);
    return WORD_W * words;
  endfunction

  function automatic int offs_width(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_mem_word_ram.sv
// rtl/dcache_mem_word_ram.sv - single-port 32-bit synchronous RAM, one-cycle read latency
module mem_word_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [31:0] r_rdata;

  // Write on we; read returns the pre-write contents one cycle later.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_mem_responder.sv
// rtl/dcache_mem_responder.sv - line refill/write-back responder over a word-wide RAM
module dcache_mem_responder
  import dcache_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 3,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_r,
  input  logic                         mem_w,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [32*WORDS_PER_LINE-1:0] mem_wdata,
  output logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  output logic                         mem_ready,
  output logic                         busy,
  output logic                         err
);

  localparam int LW    = line_width(WORDS_PER_LINE);
  localparam int OW    = offs_width(WORDS_PER_LINE);
  localparam int LA_W  = DEPTH_LOG2 - OW;
  localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [OW-1:0]    BEAT_LAST = OW'(WORDS_PER_LINE - 1);

  state_t             r_state;
  state_t             w_next;
  logic [LAT_W-1:0]   r_lat;
  logic [OW-1:0]      r_beat;
  logic               r_is_write;
  logic [LA_W-1:0]    r_line_addr;
  logic [LW-1:0]      r_wdata;
  logic [LW-1:0]      r_rdata;
  logic               r_err;
  logic               r_cap_en;
  logic [OW-1:0]      r_cap_idx;

  logic               w_accept;
  logic               w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [31:0]        w_ram_wdata;
  logic [31:0]        w_ram_rdata;
  logic               w_unused_addr;

  // Byte/word-offset bits and bits above the RAM range do not select a line.
  assign w_unused_addr = ^{mem_addr[OW+1:0], mem_addr[ADDR_W-1:DEPTH_LOG2+2]};

  assign w_accept    = (r_state == ST_IDLE) && (mem_r || mem_w);
  assign w_ram_we    = (r_state == ST_XFER) && r_is_write;
  assign w_ram_addr  = {r_line_addr, r_beat};
  assign w_ram_wdata = r_wdata[32*r_beat +: 32];

  mem_word_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // State register; reset aborts any transaction without a ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: latency wait, one beat per cycle, drain for the last read word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_r || mem_w) begin
          w_next = (LATENCY == 0) ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat == LAT_LAST) begin
          w_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (r_beat == BEAT_LAST) begin
          w_next = r_is_write ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request capture at acceptance; write wins a conflict and flags err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write  <= 1'b0;
      r_line_addr <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_is_write  <= mem_w;
      r_line_addr <= mem_addr[DEPTH_LOG2+1:OW+2];
      r_wdata     <= mem_wdata;
      if (mem_r && mem_w) begin
        r_err <= 1'b1;
      end
    end
  end

  // Latency and beat counters; beat wraps to zero after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat  <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_lat  <= '0;
      r_beat <= '0;
    end else begin
      if (r_state == ST_WAIT) begin
        r_lat <= r_lat + LAT_W'(1);
      end
      if (r_state == ST_XFER) begin
        r_beat <= r_beat + OW'(1);
      end
    end
  end

  // Read words land in their line slot one cycle after issue; nothing else touches mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
      r_rdata   <= '0;
    end else begin
      r_cap_en  <= (r_state == ST_XFER) && !r_is_write;
      r_cap_idx <= r_beat;
      if (r_cap_en) begin
        r_rdata[32*r_cap_idx +: 32] <= w_ram_rdata;
      end
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule
